// File: rtl/sens_pkg.sv
// Shared definitions for the sensor sequencing controller: FSM encoding,
// sens_mode bit positions and default sizes.
package sens_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_REQ  = 2'd2,
    ST_WAIT = 2'd3
  } sens_state_e;

  localparam int MODE_POWERDOWN = 0;
  localparam int MODE_LATEST    = 1;
  localparam int MODE_STREAM    = 2;
  localparam int MODE_GEN_IRQ   = 3;

  localparam int FIFO_DEPTH_DEF = 64;
  localparam int LVL_W          = 7;

  function automatic logic mode_run(input logic [7:0] mode);
    return !mode[MODE_POWERDOWN] && (mode[MODE_LATEST] || mode[MODE_STREAM]);
  endfunction

endpackage

// File: rtl/sens_dn_counter.sv
// Loadable down-counter that stops at zero; one instance times wake,
// sample period and ack timeout since only one is ever active.
module sens_dn_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sens_seq_ctrl.sv
// Sensor AFE sequencer: power-up settle, periodic sample requests with ack
// timeout, FIFO level tracking and sticky interrupt/error flags.
//
//   state | meaning
//   OFF   | AFE unpowered, waiting for run
//   WAKE  | AFE powered, settle timer running
//   REQ   | afe_req high, waiting for afe_ack or timeout
//   WAIT  | sample period timer running before next request
module sens_seq_ctrl
  import sens_pkg::*;
#(
  parameter int WAKE_CYCLES = 16,
  parameter int ACK_TIMEOUT = 255,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       sens_mode,
  input  logic [7:0]       sample_period,
  input  logic [LVL_W-1:0] irq_wmark,
  input  logic             irq_clr,
  input  logic             afe_ack,
  input  logic             fifo_wr,
  input  logic             fifo_rd,
  output logic             afe_pwr_en,
  output logic             afe_req,
  output logic             fifo_flush,
  output logic             irq,
  output logic [LVL_W-1:0] fifo_level,
  output logic [1:0]       state,
  output logic [1:0]       err
);

  localparam int MAX_A = (WAKE_CYCLES > ACK_TIMEOUT) ? WAKE_CYCLES : ACK_TIMEOUT;
  localparam int MAX_L = (MAX_A > 256) ? MAX_A : 256;
  localparam int CNT_W = $clog2(MAX_L);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [LVL_W-1:0] DEPTH   = LVL_W'(FIFO_DEPTH);

  sens_state_e      st_q, st_nxt;
  logic             run, stream, latest, gen_irq;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic [7:0]       period_m1;
  logic             tmo_set, ovf_set, flush_evt, wmark_hit, ack_in_req, irq_set;
  logic             ovf, tmo;
  logic [LVL_W-1:0] lvl_nxt;

  assign run       = mode_run(sens_mode);
  assign stream    = sens_mode[MODE_STREAM];
  assign latest    = sens_mode[MODE_LATEST];
  assign gen_irq   = sens_mode[MODE_GEN_IRQ];
  assign period_m1 = (sample_period == 8'd0) ? 8'd0 : sample_period - 8'd1;

  sens_dn_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    st_nxt   = st_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    tmo_set  = 1'b0;
    // Losing run beats every other transition and parks the timer at zero.
    if ((st_q != ST_OFF) && !run) begin
      st_nxt   = ST_OFF;
      cnt_load = 1'b1;
    end else begin
      case (st_q)
        ST_OFF: if (run) begin
          st_nxt   = ST_WAKE;
          cnt_load = 1'b1;
          cnt_val  = WAKE_LD;
        end
        ST_WAKE: if (cnt_zero) begin
          st_nxt   = ST_REQ;
          cnt_load = 1'b1;
          cnt_val  = TMO_LD;
        end else begin
          cnt_dec = 1'b1;
        end
        ST_REQ: if (afe_ack || cnt_zero) begin
          st_nxt   = ST_WAIT;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(period_m1);
          tmo_set  = !afe_ack;
        end else begin
          cnt_dec = 1'b1;
        end
        ST_WAIT: if (cnt_zero) begin
          st_nxt   = ST_REQ;
          cnt_load = 1'b1;
          cnt_val  = TMO_LD;
        end else begin
          cnt_dec = 1'b1;
        end
        default: st_nxt = ST_OFF;
      endcase
    end
  end

  assign flush_evt  = (st_q != ST_OFF) && !run;
  assign ovf_set    = fifo_wr && !fifo_rd && (fifo_level == DEPTH);
  assign ack_in_req = (st_q == ST_REQ) && afe_ack && latest && !stream;
  assign wmark_hit  = (irq_wmark != '0) && stream && (fifo_level >= irq_wmark);
  assign irq_set    = gen_irq && (wmark_hit || ack_in_req ||
                                  (ovf_set && !ovf) || (tmo_set && !tmo));

  // Simultaneous strobes only move the level when one side is blocked.
  always_comb begin
    lvl_nxt = fifo_level;
    if (flush_evt) begin
      lvl_nxt = '0;
    end else if (fifo_wr && !fifo_rd) begin
      if (fifo_level < DEPTH) lvl_nxt = fifo_level + 1'b1;
    end else if (fifo_rd && !fifo_wr) begin
      if (fifo_level != '0) lvl_nxt = fifo_level - 1'b1;
    end else if (fifo_wr && fifo_rd) begin
      if (fifo_level == '0)        lvl_nxt = fifo_level + 1'b1;
      else if (fifo_level == DEPTH) lvl_nxt = fifo_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= ST_OFF;
      afe_pwr_en <= 1'b0;
      afe_req    <= 1'b0;
      fifo_flush <= 1'b0;
      irq        <= 1'b0;
      fifo_level <= '0;
      ovf        <= 1'b0;
      tmo        <= 1'b0;
    end else begin
      st_q       <= st_nxt;
      afe_pwr_en <= (st_nxt != ST_OFF);
      afe_req    <= (st_nxt == ST_REQ);
      fifo_flush <= flush_evt;
      fifo_level <= lvl_nxt;
      ovf        <= ovf_set | (ovf & !irq_clr);
      tmo        <= tmo_set | (tmo & !irq_clr);
      irq        <= irq_set | (irq & !irq_clr);
    end
  end

  assign state = st_q;
  assign err   = {ovf, tmo};

endmodule
